// File: rtl/flop_compare_sequencer.sv
// flop_compare_sequencer
// Paces a spec-vs-impl flop comparison harness: issues stimulus and clock
// update strobes in fixed phase order, skips a warm-up period, then samples
// the per-lane equivalence results and keeps a pass/fail summary.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start (after reset or abort)
// S_WARMUP | stepping the harness, results ignored
// S_CHECK  | stepping the harness, results sampled once per step
// S_DONE   | run complete, summary held until the next start
module flop_compare_sequencer #(
    parameter int LANES  = 16,
    parameter int STEP   = 3,
    parameter int WARMUP = 10,
    parameter int RUN    = 1000,
    parameter int CNTW   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [LANES-1:0] ok,
    output logic             stim_upd,
    output logic             clk_upd,
    output logic             check_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNTW-1:0]  fail_count,
    output logic [CNTW-1:0]  first_fail_step,
    output logic [LANES-1:0] first_fail_lanes,
    output logic [LANES-1:0] sticky_lanes
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WARMUP = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int PW = $clog2(STEP);
    localparam logic [PW-1:0]   PHASE_LAST = PW'(STEP - 1);
    localparam logic [PW-1:0]   PHASE_CLK  = PW'(1);
    // WARM_LAST is never compared when WARMUP is 0 (WARMUP is skipped).
    localparam logic [CNTW-1:0] WARM_LAST  = CNTW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [CNTW-1:0] RUN_LAST   = CNTW'(RUN - 1);
    localparam logic [CNTW-1:0] FAIL_MAX   = '1;
    localparam logic [1:0]      S_FIRST    = (WARMUP == 0) ? S_CHECK : S_WARMUP;

    logic [1:0]       state;
    logic [PW-1:0]    phase;
    logic [CNTW-1:0]  step_cnt;
    logic [LANES-1:0] fail_mask;
    logic             is_busy;
    logic             sample_pt;
    logic             launch;
    logic             check_hit;

    assign is_busy   = (state == S_WARMUP) || (state == S_CHECK);
    assign sample_pt = is_busy && (phase == PHASE_LAST);
    assign launch    = !is_busy && start;
    assign check_hit = (state == S_CHECK) && sample_pt && !abort && (|fail_mask);

    // Lane fails unless ok is a clean 1; an X or Z on ok takes the else branch.
    always_comb begin
        fail_mask = '1;
        for (int i = 0; i < LANES; i++) begin
            if (ok[i]) begin
                fail_mask[i] = 1'b0;
            end
        end
    end

    // Sequencing FSM with phase and step counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            phase    <= '0;
            step_cnt <= '0;
        end else if (launch) begin
            state    <= S_FIRST;
            phase    <= '0;
            step_cnt <= '0;
        end else if (is_busy) begin
            if (abort) begin
                state    <= S_IDLE;
                phase    <= '0;
                step_cnt <= '0;
            end else begin
                phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
                if (sample_pt) begin
                    if ((state == S_WARMUP) && (step_cnt == WARM_LAST)) begin
                        state    <= S_CHECK;
                        step_cnt <= '0;
                    end else if ((state == S_CHECK) && (step_cnt == RUN_LAST)) begin
                        state <= S_DONE;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Result collection; a zero fail_count marks "no failure recorded yet"
    // because the counter saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_count       <= '0;
            first_fail_step  <= '0;
            first_fail_lanes <= '0;
            sticky_lanes     <= '0;
        end else if (launch) begin
            fail_count       <= '0;
            first_fail_step  <= '0;
            first_fail_lanes <= '0;
            sticky_lanes     <= '0;
        end else if (check_hit) begin
            if (fail_count == '0) begin
                first_fail_step  <= step_cnt;
                first_fail_lanes <= fail_mask;
            end
            if (fail_count != FAIL_MAX) begin
                fail_count <= fail_count + 1'b1;
            end
            sticky_lanes <= sticky_lanes | fail_mask;
        end
    end

    assign busy     = is_busy;
    assign stim_upd = is_busy && (phase == '0);
    assign clk_upd  = is_busy && (phase == PHASE_CLK);
    assign check_en = (state == S_CHECK);
    assign done     = (state == S_DONE);
    assign pass     = (state == S_DONE) && (fail_count == '0);

endmodule

// File: tb/tb_flop_compare_sequencer.sv
// Bench for flop_compare_sequencer: directed scenarios plus random runs,
// compared every cycle against a cycle-index model of a run.
module tb_flop_compare_sequencer;

    localparam int LANES  = 4;
    localparam int STEP   = 3;
    localparam int WARMUP = 2;
    localparam int RUN    = 4;
    localparam int NCYC   = 64;
    localparam int RUNLEN = (WARMUP + RUN) * STEP;

    logic       clk = 1'b0;
    logic       reset, start, abort;
    logic [3:0] ok;

    logic        a_stim, a_clk, a_chk, a_busy, a_done, a_pass;
    logic [15:0] a_fc, a_ffs;
    logic [3:0]  a_ffl, a_sticky;
    logic        b_stim, b_clk, b_chk, b_busy, b_done, b_pass;
    logic [1:0]  b_fc, b_ffs;
    logic [3:0]  b_ffl, b_sticky;

    logic       st_v [NCYC];
    logic       ab_v [NCYC];
    logic       rs_v [NCYC];
    logic [3:0] ok_v [NCYC];

    int total = 0;
    int bad   = 0;

    // reference model: m_mode 0 idle, 1 running, 2 done; m_j = cycles into run
    int         m_mode, m_j, m_fc, m_fc2, m_ffs;
    logic [3:0] m_ffl, m_sticky;

    flop_compare_sequencer #(.LANES(LANES), .STEP(STEP), .WARMUP(WARMUP), .RUN(RUN), .CNTW(16)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ok(ok),
        .stim_upd(a_stim), .clk_upd(a_clk), .check_en(a_chk), .busy(a_busy),
        .done(a_done), .pass(a_pass), .fail_count(a_fc), .first_fail_step(a_ffs),
        .first_fail_lanes(a_ffl), .sticky_lanes(a_sticky)
    );

    flop_compare_sequencer #(.LANES(LANES), .STEP(STEP), .WARMUP(WARMUP), .RUN(RUN), .CNTW(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ok(ok),
        .stim_upd(b_stim), .clk_upd(b_clk), .check_en(b_chk), .busy(b_busy),
        .done(b_done), .pass(b_pass), .fail_count(b_fc), .first_fail_step(b_ffs),
        .first_fail_lanes(b_ffl), .sticky_lanes(b_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_j = 0; m_fc = 0; m_fc2 = 0; m_ffs = 0;
        m_ffl = '0; m_sticky = '0;
    endtask

    task automatic model_step(input logic st, input logic ab, input logic [3:0] o);
        logic [3:0] mask;
        if (m_mode != 1) begin
            if (st) begin
                m_mode = 1; m_j = 0; m_fc = 0; m_fc2 = 0; m_ffs = 0;
                m_ffl = '0; m_sticky = '0;
            end
        end else if (ab) begin
            m_mode = 0;
        end else begin
            if ((m_j % STEP == STEP - 1) && (m_j / STEP >= WARMUP)) begin
                for (int i = 0; i < 4; i++) mask[i] = (o[i] !== 1'b1);
                if (mask != 4'h0) begin
                    if (m_fc == 0) begin
                        m_ffs = m_j / STEP - WARMUP;
                        m_ffl = mask;
                    end
                    if (m_fc < 65535) m_fc++;
                    if (m_fc2 < 3) m_fc2++;
                    m_sticky = m_sticky | mask;
                end
            end
            m_j++;
            if (m_j == RUNLEN) m_mode = 2;
        end
    endtask

    task automatic check_outputs(input int id, input int c);
        string p;
        logic e_busy, e_stim, e_clk, e_chk, e_done, e_pass;
        p      = $sformatf("s%0d.c%0d.", id, c);
        e_busy = (m_mode == 1);
        e_stim = e_busy && (m_j % STEP == 0);
        e_clk  = e_busy && (m_j % STEP == 1);
        e_chk  = e_busy && (m_j / STEP >= WARMUP);
        e_done = (m_mode == 2);
        e_pass = e_done && (m_fc == 0);
        chk({p, "busy"},     32'(a_busy),   32'(e_busy));
        chk({p, "stim_upd"}, 32'(a_stim),   32'(e_stim));
        chk({p, "clk_upd"},  32'(a_clk),    32'(e_clk));
        chk({p, "check_en"}, 32'(a_chk),    32'(e_chk));
        chk({p, "done"},     32'(a_done),   32'(e_done));
        chk({p, "pass"},     32'(a_pass),   32'(e_pass));
        chk({p, "fail_cnt"}, 32'(a_fc),     32'(m_fc));
        chk({p, "ff_step"},  32'(a_ffs),    32'(m_ffs));
        chk({p, "ff_lanes"}, 32'(a_ffl),    32'(m_ffl));
        chk({p, "sticky"},   32'(a_sticky), 32'(m_sticky));
        chk({p, "b_busy"},   32'(b_busy),   32'(e_busy));
        chk({p, "b_pass"},   32'(b_pass),   32'(e_pass));
        chk({p, "b_fc"},     32'(b_fc),     32'(m_fc2));
        chk({p, "b_ffs"},    32'(b_ffs),    32'(m_ffs));
        chk({p, "b_sticky"}, 32'(b_sticky), 32'(m_sticky));
    endtask

    task automatic clear_vecs();
        for (int c = 0; c < NCYC; c++) begin
            st_v[c] = 1'b0; ab_v[c] = 1'b0; rs_v[c] = 1'b0; ok_v[c] = 4'hF;
        end
        st_v[0] = 1'b1;
    endtask

    task automatic run_scn(input int id, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check_outputs(id, c);
            start = st_v[c];
            abort = ab_v[c];
            ok    = ok_v[c];
            if (rs_v[c]) begin
                reset = 1'b1;
                #1;
                model_reset();
                check_outputs(id, c);
            end else begin
                reset = 1'b0;
                model_step(st_v[c], ab_v[c], ok_v[c]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; ok = 4'hF;
        model_reset();
        #1;
        check_outputs(0, 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: clean run
        clear_vecs();
        run_scn(1, 22);
        chk("s1.end.pass", 32'(a_pass), 32'd1);
        chk("s1.end.fc",   32'(a_fc),   32'd0);

        // 2: failure during warm-up is ignored
        clear_vecs();
        ok_v[3] = 4'b1011;
        run_scn(2, 22);
        chk("s2.end.pass",   32'(a_pass),   32'd1);
        chk("s2.end.sticky", 32'(a_sticky), 32'd0);

        // 3: two failing samples on different lanes
        clear_vecs();
        ok_v[12] = 4'b1011;
        ok_v[18] = 4'b0111;
        run_scn(3, 22);
        chk("s3.end.fc",     32'(a_fc),     32'd2);
        chk("s3.end.ffs",    32'(a_ffs),    32'd1);
        chk("s3.end.ffl",    32'(a_ffl),    32'h4);
        chk("s3.end.sticky", 32'(a_sticky), 32'hC);
        chk("s3.end.pass",   32'(a_pass),   32'd0);

        // 4: unknown on lane 0 at the first check sample
        clear_vecs();
        ok_v[9] = 4'b111x;
        run_scn(4, 22);
        chk("s4.end.fc",  32'(a_fc),  32'd1);
        chk("s4.end.ffs", 32'(a_ffs), 32'd0);
        chk("s4.end.ffl", 32'(a_ffl), 32'h1);

        // 5: abort, restart with start+abort together, start while busy, reset mid-run
        clear_vecs();
        ok_v[9]  = 4'b1110;
        ab_v[10] = 1'b1;
        st_v[12] = 1'b1;
        ab_v[12] = 1'b1;
        st_v[16] = 1'b1;
        rs_v[26] = 1'b1;
        run_scn(5, 30);
        chk("s5.end.busy", 32'(a_busy), 32'd0);
        chk("s5.end.fc",   32'(a_fc),   32'd0);

        // 6: every sample fails; narrow counter saturates
        clear_vecs();
        ok_v[9] = 4'h0; ok_v[12] = 4'h0; ok_v[15] = 4'h0; ok_v[18] = 4'h0;
        run_scn(6, 22);
        chk("s6.end.b_fc",     32'(b_fc),     32'd3);
        chk("s6.end.b_ffs",    32'(b_ffs),    32'd0);
        chk("s6.end.b_sticky", 32'(b_sticky), 32'hF);
        chk("s6.end.a_fc",     32'(a_fc),     32'd4);

        // random runs
        for (int r = 0; r < 8; r++) begin
            clear_vecs();
            for (int c = 1; c < 40; c++) begin
                st_v[c] = ($urandom_range(0, 11) == 0);
                ab_v[c] = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 3) == 0) ok_v[c] = 4'($urandom_range(0, 15));
            end
            run_scn(10 + r, 40);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flop_compare_sequencer.md
Name: flop_compare_sequencer

Overview:
- Controller that paces a spec-vs-impl flop comparison harness.
- Drives stimulus-update and clock-update strobes in a fixed phase order, so data and clock never change in the same cycle.
- Gates the checking window behind a warm-up period and collects per-lane mismatch results into a pass/fail summary.
- Sits between the random stimulus generators, the clock gate and the per-lane equivalence "ok" signals of the comparison bench.

Parameters:
- LANES, 16: number of independent ok lanes checked.
- STEP, 3: cycles per stimulus step; legal values are >= 3.
- WARMUP, 10: steps run before checking starts; 0 is legal.
- RUN, 1000: steps checked; legal values are >= 1.
- CNTW, 16: width of the fail counter and of the step index.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin a run; honoured only in IDLE or DONE.
- abort  in  1  cancel an in-progress run.
- ok  in  LANES  per-lane equivalence result; a lane passes only if exactly 1'b1.
- stim_upd  out  1  strobe: stimulus generators advance.
- clk_upd  out  1  strobe: harness clock toggles/advances.
- check_en  out  1  high throughout the CHECK state.
- busy  out  1  state is WARMUP or CHECK.
- done  out  1  run completed normally; held until start or reset.
- pass  out  1  done with zero failures.
- fail_count  out  CNTW  number of failing samples, saturating.
- first_fail_step  out  CNTW  CHECK step index of the first failing sample.
- first_fail_lanes  out  LANES  failing-lane mask at the first failure.
- sticky_lanes  out  LANES  OR of every failing-lane mask seen.

Behaviour:
- States: IDLE, WARMUP, CHECK, DONE. State, phase (0..STEP-1) and step_cnt are registers. All outputs are decoded from registers only, never from inputs.
- Reset: state=IDLE, phase=0, step_cnt=0. Every output is 0.
- IDLE/DONE + start: on the next edge, go to WARMUP (or CHECK if WARMUP=0).
  - phase and step_cnt reset to 0.
  - fail_count, first_fail_*, sticky_lanes clear.
  - done and pass drop.
- start while busy is ignored.
- Phase advances every cycle while busy and wraps at STEP-1.
  - stim_upd = busy & phase==0.
  - clk_upd = busy & phase==1.
  - Sample point = phase==STEP-1.
- At each sample point, step_cnt increments.
  - WARMUP: when step_cnt reaches WARMUP-1, go to CHECK and clear step_cnt.
  - CHECK: when step_cnt reaches RUN-1, go to DONE.
- Failure sampling, at a CHECK sample point only:
  - fail_mask = bit i set iff ok[i] !== 1'b1. X and Z count as failures.
  - If fail_mask is nonzero: fail_count increments, saturating at 2^CNTW-1, and sticky_lanes |= fail_mask.
  - If this is the first failure: first_fail_step = step_cnt, first_fail_lanes = fail_mask.
- ok is ignored outside CHECK sample points, including during warm-up.
- DONE: done=1; pass=(fail_count==0). Counters and masks hold.
- abort while busy: go to IDLE next edge with done=0 and pass=0. Counters hold until the next start.
- abort has priority over the sample-point transition in the same cycle. abort outside busy has no effect.
- start and abort in the same cycle while in IDLE/DONE: start wins.
- reset mid-run: immediate asynchronous return to the reset state. Strobes drop in the same cycle.

Test Plan:
- Common setup for every scenario: LANES=4, STEP=3, WARMUP=2, RUN=4, CNTW=16; start is pulsed in cycle 0.
- 1. ok=4'hF throughout.
  - busy in cycles 1–18; stim_upd at 1,4,…,16; clk_upd at 2,5,…,17.
  - check_en in cycles 7–18; samples at 9,12,15,18.
  - done=1 from cycle 19 with pass=1 and fail_count=0.
- 2. ok=4'b1011 in cycle 3 (warm-up), otherwise 4'hF.
  - Expect pass=1, fail_count=0, sticky_lanes=0.
- 3. ok=4'b1011 in cycle 12 and 4'b0111 in cycle 18.
  - Expect fail_count=2, first_fail_step=1, first_fail_lanes=4'b0100, sticky_lanes=4'b1100, pass=0.
- 4. ok[0]=1'bx in cycle 9.
  - Expect fail_count=1, first_fail_step=0, first_fail_lanes=4'b0001.
- 5. abort in cycle 10.
  - Cycle 11: IDLE, busy=0, done=0, fail_count held.
  - A restart clears the counters.
  - reset pulsed in cycle 14 of a new run zeroes every output in that same cycle.
- 6. CNTW=2, ok=4'h0 at every sample.
  - Expect fail_count=3 (saturated), first_fail_step=0, sticky_lanes=4'hF.
